// File: rtl/spi_word_peripheral_if.sv
// Word-side bundle between spi_word_peripheral and the command decoder.
// Latency: none, wires only.
// Backpressure: rx_valid is held until the consumer raises rx_ack; tx side is pull-only via tx_load.
interface spi_word_peripheral_if #(
    parameter int W = 64
);
    logic [W-1:0] tx_word;
    logic         tx_load;
    logic [W-1:0] rx_word;
    logic         rx_valid;
    logic         rx_ack;
    logic         busy;
`ifdef SPI_OVERRUN_EN
    logic         rx_overrun;

    modport slave (
        input  tx_word, rx_ack,
        output tx_load, rx_word, rx_valid, busy, rx_overrun
    );

    modport master (
        output tx_word, rx_ack,
        input  tx_load, rx_word, rx_valid, busy, rx_overrun
    );
`else
    modport slave (
        input  tx_word, rx_ack,
        output tx_load, rx_word, rx_valid, busy
    );

    modport master (
        output tx_word, rx_ack,
        input  tx_load, rx_word, rx_valid, busy
    );
`endif
endinterface

// File: rtl/spi_word_peripheral.sv
// Word-framed SPI peripheral, any CPOL/CPHA, WORD_BYTES-byte words; SPI_OVERRUN_EN adds sticky rx_overrun.
// Latency: rx_word/rx_valid SYNC_STAGES clk after the final sample edge reaches the pins; busy SYNC_STAGES-1 after CS falls.
// Backpressure: none toward SPI; rx_valid held until rx_ack, a newer word overwrites the unconsumed one.
module spi_word_peripheral #(
    parameter int WORD_BYTES     = 8,
    parameter int CPOL           = 0,
    parameter int CPHA           = 0,
    parameter int SYNC_STAGES    = 3,
    parameter int LSB_BYTE_FIRST = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 SCK,
    input  logic                 CS,
    input  logic                 COPI,
    output logic                 CIPO,
    spi_word_peripheral_if.slave bus
);
    localparam int   W    = 8 * WORD_BYTES;
    localparam int   CW   = $clog2(W);
    localparam logic IDLE = (CPOL != 0);

    // Maps between word layout and wire order: the first byte on the wire sits in the top byte of the
    // shift registers. The mapping is its own inverse, so it serves both directions.
    function automatic logic [W-1:0] byte_order(input logic [W-1:0] w);
        logic [W-1:0] r;
        r = w;
        if (LSB_BYTE_FIRST != 0) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                r[W-1-8*i -: 8] = w[8*i +: 8];
            end
        end
        return r;
    endfunction

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-2:0]  rx_sh_q, rx_sh_d;
    logic [W-1:0]  tx_sh_q, tx_sh_d;
    logic [W-1:0]  rx_word_q, rx_word_d;
    logic          rx_valid_q, rx_valid_d;
    logic          tx_load_q, tx_load_d;
    logic          sampled_q, sampled_d;
`ifdef SPI_OVERRUN_EN
    logic          rx_overrun_q, rx_overrun_d;
`endif

    logic sck_prev, sck_cur;
    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic cs_act, frame_start, copi_bit;
    logic word_done;

    // Synchroniser shift chains for the three asynchronous pins.
    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], SCK};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], CS};
        copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], COPI};
    end

    // Edges are judged on the two oldest stages. COPI is taken from the oldest stage, i.e. the value
    // present one cycle before the detected SCK transition, which keeps sampling on the setup side.
    assign sck_prev    = sck_sync_q[SYNC_STAGES-1];
    assign sck_cur     = sck_sync_q[SYNC_STAGES-2];
    assign lead_edge   = (sck_prev == IDLE) && (sck_cur != IDLE);
    assign trail_edge  = (sck_prev != IDLE) && (sck_cur == IDLE);
    assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
    assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;
    assign cs_act      = ~cs_sync_q[SYNC_STAGES-2];
    assign frame_start = cs_sync_q[SYNC_STAGES-1] & ~cs_sync_q[SYNC_STAGES-2];
    assign copi_bit    = copi_sync_q[SYNC_STAGES-1];

    // Framing, bit counting, shift registers and the rx handshake.
    always_comb begin
        cnt_d      = cnt_q;
        rx_sh_d    = rx_sh_q;
        tx_sh_d    = tx_sh_q;
        rx_word_d  = rx_word_q;
        rx_valid_d = rx_valid_q;
        tx_load_d  = 1'b0;
        sampled_d  = sampled_q;
        word_done  = 1'b0;
`ifdef SPI_OVERRUN_EN
        rx_overrun_d = rx_overrun_q;
`endif

        if (frame_start) begin
            cnt_d     = '0;
            sampled_d = 1'b0;
            tx_sh_d   = byte_order(bus.tx_word);
            tx_load_d = 1'b1;
        end else if (!cs_act) begin
            // Deselected, including mid-word: drop the partial word without touching rx_word.
            cnt_d     = '0;
            sampled_d = 1'b0;
        end else if (sample_edge) begin
            rx_sh_d   = {rx_sh_q[W-3:0], copi_bit};
            sampled_d = 1'b1;
            if (cnt_q == CW'(W - 1)) begin
                cnt_d     = '0;
                word_done = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (shift_edge && sampled_q) begin
            // Counter at 0 after a sample means the word just wrapped: present the next word instead.
            if (cnt_q == '0) begin
                tx_sh_d   = byte_order(bus.tx_word);
                tx_load_d = 1'b1;
            end else begin
                tx_sh_d = {tx_sh_q[W-2:0], 1'b0};
            end
        end

        if (rx_valid_q && bus.rx_ack) begin
            rx_valid_d = 1'b0;
`ifdef SPI_OVERRUN_EN
            rx_overrun_d = 1'b0;
`endif
        end
        // A completing word takes priority over an ack in the same cycle.
        if (word_done) begin
            rx_valid_d = 1'b1;
            rx_word_d  = byte_order({rx_sh_q, copi_bit});
`ifdef SPI_OVERRUN_EN
            if (rx_valid_q && !bus.rx_ack) begin
                rx_overrun_d = 1'b1;
            end
`endif
        end
    end

    // State register with synchronous reset; synchronisers preload the idle pin levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync_q   <= {SYNC_STAGES{IDLE}};
            cs_sync_q    <= {SYNC_STAGES{1'b1}};
            copi_sync_q  <= '0;
            cnt_q        <= '0;
            rx_sh_q      <= '0;
            tx_sh_q      <= '0;
            rx_word_q    <= '0;
            rx_valid_q   <= 1'b0;
            tx_load_q    <= 1'b0;
            sampled_q    <= 1'b0;
`ifdef SPI_OVERRUN_EN
            rx_overrun_q <= 1'b0;
`endif
        end else begin
            sck_sync_q   <= sck_sync_d;
            cs_sync_q    <= cs_sync_d;
            copi_sync_q  <= copi_sync_d;
            cnt_q        <= cnt_d;
            rx_sh_q      <= rx_sh_d;
            tx_sh_q      <= tx_sh_d;
            rx_word_q    <= rx_word_d;
            rx_valid_q   <= rx_valid_d;
            tx_load_q    <= tx_load_d;
            sampled_q    <= sampled_d;
`ifdef SPI_OVERRUN_EN
            rx_overrun_q <= rx_overrun_d;
`endif
        end
    end

    // tx_load is registered, so it follows the capture cycle by one clk.
    assign CIPO         = cs_act ? tx_sh_q[W-1] : 1'bz;
    assign bus.tx_load  = tx_load_q;
    assign bus.rx_word  = rx_word_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.busy     = cs_act;
`ifdef SPI_OVERRUN_EN
    assign bus.rx_overrun = rx_overrun_q;
`endif
endmodule

// File: tb/tb_spi_word_peripheral.sv
// Bench for spi_word_peripheral: a mode-0 64-bit instance and a mode-3 16-bit MSB-byte-first instance.
// Latency: checks rx_valid SYNC_STAGES clk after the final sample edge and busy SYNC_STAGES-1 after CS falls.
// Backpressure: drives rx_ack explicitly, including an ack coinciding with a completion.
module tb_spi_word_peripheral;
    localparam int S = 3;
    localparam int H = 8;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        sck  [2];
    logic        cs   [2];
    logic        copi [2];
    logic        ack  [2];
    logic [63:0] txw  [2];
    wire         cipo_a, cipo_b;
    wire  [63:0] rxw  [2];
    wire         rxv  [2];
    wire         load [2];
    wire         bsy  [2];
`ifdef SPI_OVERRUN_EN
    wire         ovr  [2];
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int nload    [2] = '{0, 0};
    int nrise    [2] = '{0, 0};
    int nchg     [2] = '{0, 0};
    int rise_cyc [2] = '{0, 0};
    int samp_cyc [2] = '{0, 0};
    logic [63:0] rxw_prev [2] = '{64'd0, 64'd0};
    logic        rxv_prev [2] = '{1'b0, 1'b0};
    bit mosi_q [$];
    bit miso_q [$];

    spi_word_peripheral_if #(.W(64)) bus_a ();
    spi_word_peripheral_if #(.W(16)) bus_b ();

    spi_word_peripheral #(.WORD_BYTES(8)) dut_a (
        .clk(clk), .reset(reset), .SCK(sck[0]), .CS(cs[0]), .COPI(copi[0]), .CIPO(cipo_a), .bus(bus_a)
    );
    spi_word_peripheral #(.WORD_BYTES(2), .CPOL(1), .CPHA(1), .LSB_BYTE_FIRST(0)) dut_b (
        .clk(clk), .reset(reset), .SCK(sck[1]), .CS(cs[1]), .COPI(copi[1]), .CIPO(cipo_b), .bus(bus_b)
    );

    assign bus_a.tx_word = txw[0];
    assign bus_b.tx_word = txw[1][15:0];
    assign bus_a.rx_ack  = ack[0];
    assign bus_b.rx_ack  = ack[1];
    assign rxw[0]  = bus_a.rx_word;
    assign rxw[1]  = {48'd0, bus_b.rx_word};
    assign rxv[0]  = bus_a.rx_valid;
    assign rxv[1]  = bus_b.rx_valid;
    assign load[0] = bus_a.tx_load;
    assign load[1] = bus_b.tx_load;
    assign bsy[0]  = bus_a.busy;
    assign bsy[1]  = bus_b.busy;
`ifdef SPI_OVERRUN_EN
    assign ovr[0]  = bus_a.rx_overrun;
    assign ovr[1]  = bus_b.rx_overrun;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event counters observed between clock edges.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (load[i] === 1'b1) nload[i] = nload[i] + 1;
            if (rxv[i] === 1'b1 && rxv_prev[i] !== 1'b1) begin
                nrise[i]    = nrise[i] + 1;
                rise_cyc[i] = cyc;
            end
            if (rxw[i] !== rxw_prev[i]) nchg[i] = nchg[i] + 1;
            rxv_prev[i] = rxv[i];
            rxw_prev[i] = rxw[i];
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

    // Instance configuration as seen by the reference model.
    function automatic int f_w(input int inst);
        return (inst == 0) ? 64 : 16;
    endfunction
    function automatic logic f_cpol(input int inst);
        return (inst == 0) ? 1'b0 : 1'b1;
    endfunction
    function automatic int f_cpha(input int inst);
        return (inst == 0) ? 0 : 1;
    endfunction
    function automatic int f_lsb(input int inst);
        return (inst == 0) ? 1 : 0;
    endfunction

    // Word bit position carried by the j-th bit on the wire.
    function automatic int pos(input int inst, input int j);
        int k, b, idx;
        k   = j / 8;
        b   = 7 - (j % 8);
        idx = (f_lsb(inst) != 0) ? k : (f_w(inst) / 8 - 1 - k);
        return 8 * idx + b;
    endfunction

    function automatic logic [63:0] recon(input int inst, input int start);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < f_w(inst); j++) r[pos(inst, j)] = miso_q[start + j];
        return r;
    endfunction

    function automatic logic [63:0] rand_word(input int inst);
        logic [63:0] r;
        r = {$urandom, $urandom};
        if (f_w(inst) == 16) r = r & 64'hFFFF;
        return r;
    endfunction

    function automatic logic get_cipo(input int inst);
        return (inst == 0) ? cipo_a : cipo_b;
    endfunction

    task automatic fill_mosi(input int inst, input logic [63:0] w);
        for (int j = 0; j < f_w(inst); j++) mosi_q.push_back(w[pos(inst, j)]);
    endtask

    task automatic sample_tail(input int inst, input bit with_ack);
        if (with_ack) begin
            repeat (S - 1) @(negedge clk);
            ack[inst] = 1'b1;
            @(negedge clk);
            ack[inst] = 1'b0;
            repeat (H - S) @(negedge clk);
        end else begin
            repeat (H) @(negedge clk);
        end
    endtask

    // Controller model: plays mosi_q, records CIPO at each sample edge.
    task automatic drive_frame(input int inst, input int nbits, input bit ack_last, input bit keep_cs);
        logic idle;
        idle = f_cpol(inst);
        miso_q.delete();
        cs[inst] = 1'b0;
        repeat (S + 3) @(negedge clk);
        for (int j = 0; j < nbits; j++) begin
            if (f_cpha(inst) == 0) begin
                copi[inst] = mosi_q[j];
                repeat (H) @(negedge clk);
                miso_q.push_back(get_cipo(inst));
                sck[inst] = ~idle;
                samp_cyc[inst] = cyc;
                sample_tail(inst, ack_last && (j == nbits - 1));
                sck[inst] = idle;
            end else begin
                sck[inst]  = ~idle;
                copi[inst] = mosi_q[j];
                repeat (H) @(negedge clk);
                miso_q.push_back(get_cipo(inst));
                sck[inst] = idle;
                samp_cyc[inst] = cyc;
                sample_tail(inst, ack_last && (j == nbits - 1));
            end
        end
        repeat (H) @(negedge clk);
        if (!keep_cs) begin
            cs[inst] = 1'b1;
            repeat (S + 3) @(negedge clk);
        end
    endtask

    task automatic ack_word(input int inst);
        ack[inst] = 1'b1;
        @(negedge clk);
        ack[inst] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (rxv[i] !== 1'b0) $display("FAIL reset_rx_valid[%0d] got %b want 0", i, rxv[i]); else n_pass++;
            n_checks++; if (rxw[i] !== 64'd0) $display("FAIL reset_rx_word[%0d] got %h want 0", i, rxw[i]); else n_pass++;
            n_checks++; if (bsy[i] !== 1'b0) $display("FAIL reset_busy[%0d] got %b want 0", i, bsy[i]); else n_pass++;
            n_checks++; if (load[i] !== 1'b0) $display("FAIL reset_tx_load[%0d] got %b want 0", i, load[i]); else n_pass++;
`ifdef SPI_OVERRUN_EN
            n_checks++; if (ovr[i] !== 1'b0) $display("FAIL reset_overrun[%0d] got %b want 0", i, ovr[i]); else n_pass++;
`endif
        end
        reset = 1'b0;
        repeat (S + 2) @(negedge clk);
        n_checks++; if (bsy[0] !== 1'b0) $display("FAIL idle_busy got %b want 0", bsy[0]); else n_pass++;
    endtask

    task automatic test_busy();
        cs[1] = 1'b0;
        repeat (S - 2) @(negedge clk);
        n_checks++; if (bsy[1] !== 1'b0) $display("FAIL busy_early got %b want 0", bsy[1]); else n_pass++;
        @(negedge clk);
        n_checks++; if (bsy[1] !== 1'b1) $display("FAIL busy_rise got %b want 1", bsy[1]); else n_pass++;
        cs[1] = 1'b1;
        repeat (S + 3) @(negedge clk);
        n_checks++; if (bsy[1] !== 1'b0) $display("FAIL busy_fall got %b want 0", bsy[1]); else n_pass++;
    endtask

    task automatic test_mode0_word();
        logic [63:0] tx, rx, got;
        logic [7:0]  first;
        int l0;
        tx = 64'h0807060504030201;
        rx = 64'h8877665544332211;
        txw[0] = tx;
        mosi_q.delete();
        fill_mosi(0, rx);
        l0 = nload[0];
        drive_frame(0, 64, 1'b0, 1'b0);
        got = recon(0, 0);
        for (int j = 0; j < 8; j++) first[7 - j] = miso_q[j];
        n_checks++; if (rxw[0] !== rx) $display("FAIL m0_rx_word got %h want %h", rxw[0], rx); else n_pass++;
        n_checks++; if (rxv[0] !== 1'b1) $display("FAIL m0_rx_valid got %b want 1", rxv[0]); else n_pass++;
        n_checks++; if (got !== tx) $display("FAIL m0_cipo_word got %h want %h", got, tx); else n_pass++;
        n_checks++; if (first !== 8'h01) $display("FAIL m0_cipo_first_byte got %h want 01", first); else n_pass++;
        n_checks++; if (rise_cyc[0] - samp_cyc[0] !== S) $display("FAIL m0_latency got %0d want %0d", rise_cyc[0] - samp_cyc[0], S); else n_pass++;
        n_checks++; if (nload[0] - l0 !== 2) $display("FAIL m0_tx_load_count got %0d want 2", nload[0] - l0); else n_pass++;
        ack_word(0);
        n_checks++; if (rxv[0] !== 1'b0) $display("FAIL m0_ack_clear got %b want 0", rxv[0]); else n_pass++;
    endtask

    task automatic test_mode3_word();
        logic [63:0] got;
        int l0;
        txw[1] = 64'h3C3C;
        mosi_q.delete();
        fill_mosi(1, 64'hA55A);
        l0 = nload[1];
        drive_frame(1, 16, 1'b0, 1'b0);
        got = recon(1, 0);
        n_checks++; if (rxw[1] !== 64'hA55A) $display("FAIL m3_rx_word got %h want a55a", rxw[1]); else n_pass++;
        n_checks++; if (rxv[1] !== 1'b1) $display("FAIL m3_rx_valid got %b want 1", rxv[1]); else n_pass++;
        n_checks++; if (miso_q[0] !== txw[1][15]) $display("FAIL m3_first_cipo got %b want %b", miso_q[0], txw[1][15]); else n_pass++;
        n_checks++; if (got !== 64'h3C3C) $display("FAIL m3_cipo_word got %h want 3c3c", got); else n_pass++;
        n_checks++; if (nload[1] - l0 !== 1) $display("FAIL m3_tx_load_count got %0d want 1", nload[1] - l0); else n_pass++;
        ack_word(1);
    endtask

    task automatic test_back_to_back();
        logic [63:0] w1, w2, tx, g1, g2;
        int l0, c0;
        tx = rand_word(1);
        do w1 = rand_word(1); while (w1 == rxw[1]);
        do w2 = rand_word(1); while (w2 == w1);
        txw[1] = tx;
        mosi_q.delete();
        fill_mosi(1, w1);
        fill_mosi(1, w2);
        l0 = nload[1];
        c0 = nchg[1];
        drive_frame(1, 32, 1'b0, 1'b0);
        g1 = recon(1, 0);
        g2 = recon(1, 16);
        n_checks++; if (rxw[1] !== w2) $display("FAIL b2b_rx_word got %h want %h", rxw[1], w2); else n_pass++;
        n_checks++; if (rxv[1] !== 1'b1) $display("FAIL b2b_rx_valid got %b want 1", rxv[1]); else n_pass++;
        n_checks++; if (nload[1] - l0 !== 2) $display("FAIL b2b_tx_load_count got %0d want 2", nload[1] - l0); else n_pass++;
        n_checks++; if (nchg[1] - c0 !== 2) $display("FAIL b2b_word_updates got %0d want 2", nchg[1] - c0); else n_pass++;
        n_checks++; if (g1 !== tx || g2 !== tx) $display("FAIL b2b_cipo got %h/%h want %h", g1, g2, tx); else n_pass++;
`ifdef SPI_OVERRUN_EN
        n_checks++; if (ovr[1] !== 1'b1) $display("FAIL b2b_overrun got %b want 1", ovr[1]); else n_pass++;
`endif
        ack_word(1);
`ifdef SPI_OVERRUN_EN
        n_checks++; if (ovr[1] !== 1'b0) $display("FAIL b2b_overrun_clear got %b want 0", ovr[1]); else n_pass++;
`endif
    endtask

    task automatic test_partial();
        logic [63:0] old, full;
        int l0, r0, c0;
        old  = rxw[0];
        full = 64'hDEADBEEFCAFEF00D;
        mosi_q.delete();
        for (int j = 0; j < 13; j++) mosi_q.push_back(1'($urandom_range(0, 1)));
        l0 = nload[0];
        r0 = nrise[0];
        c0 = nchg[0];
        drive_frame(0, 13, 1'b0, 1'b0);
        n_checks++; if (rxv[0] !== 1'b0) $display("FAIL part_rx_valid got %b want 0", rxv[0]); else n_pass++;
        n_checks++; if (rxw[0] !== old) $display("FAIL part_rx_word got %h want %h", rxw[0], old); else n_pass++;
        n_checks++; if (nload[0] - l0 !== 1) $display("FAIL part_tx_load_count got %0d want 1", nload[0] - l0); else n_pass++;
        mosi_q.delete();
        fill_mosi(0, full);
        drive_frame(0, 64, 1'b0, 1'b0);
        n_checks++; if (rxw[0] !== full) $display("FAIL part_full_word got %h want %h", rxw[0], full); else n_pass++;
        n_checks++; if (nrise[0] - r0 !== 1) $display("FAIL part_valid_pulses got %0d want 1", nrise[0] - r0); else n_pass++;
        n_checks++; if (nchg[0] - c0 !== 1) $display("FAIL part_word_updates got %0d want 1", nchg[0] - c0); else n_pass++;
    endtask

    task automatic test_ack_same_cycle();
        logic [63:0] w;
        do w = rand_word(0); while (w == rxw[0]);
        mosi_q.delete();
        fill_mosi(0, w);
        drive_frame(0, 64, 1'b1, 1'b0);
        n_checks++; if (rxv[0] !== 1'b1) $display("FAIL ackc_rx_valid got %b want 1", rxv[0]); else n_pass++;
        n_checks++; if (rxw[0] !== w) $display("FAIL ackc_rx_word got %h want %h", rxw[0], w); else n_pass++;
`ifdef SPI_OVERRUN_EN
        n_checks++; if (ovr[0] !== 1'b0) $display("FAIL ackc_overrun got %b want 0", ovr[0]); else n_pass++;
`endif
    endtask

    task automatic test_reset_mid();
        logic [63:0] w, tx, got;
        int l0;
        mosi_q.delete();
        fill_mosi(0, rand_word(0));
        drive_frame(0, 20, 1'b0, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (rxv[0] !== 1'b0) $display("FAIL rstm_rx_valid got %b want 0", rxv[0]); else n_pass++;
        n_checks++; if (rxw[0] !== 64'd0) $display("FAIL rstm_rx_word got %h want 0", rxw[0]); else n_pass++;
        n_checks++; if (bsy[0] !== 1'b0) $display("FAIL rstm_busy got %b want 0", bsy[0]); else n_pass++;
        n_checks++; if (load[0] !== 1'b0) $display("FAIL rstm_tx_load got %b want 0", load[0]); else n_pass++;
        reset = 1'b0;
        l0 = nload[0];
        repeat (S + 3) @(negedge clk);
        n_checks++; if (bsy[0] !== 1'b1) $display("FAIL rstm_refill_busy got %b want 1", bsy[0]); else n_pass++;
        n_checks++; if (nload[0] - l0 !== 1) $display("FAIL rstm_refill_load got %0d want 1", nload[0] - l0); else n_pass++;
        cs[0] = 1'b1;
        repeat (S + 3) @(negedge clk);
        w  = rand_word(0);
        tx = rand_word(0);
        txw[0] = tx;
        mosi_q.delete();
        fill_mosi(0, w);
        drive_frame(0, 64, 1'b0, 1'b0);
        got = recon(0, 0);
        n_checks++; if (rxw[0] !== w || rxv[0] !== 1'b1) $display("FAIL rstm_next_word got %h/%b want %h/1", rxw[0], rxv[0], w); else n_pass++;
        n_checks++; if (got !== tx) $display("FAIL rstm_next_cipo got %h want %h", got, tx); else n_pass++;
        ack_word(0);
    endtask

    task automatic test_random();
        logic [63:0] tx, last, got;
        int inst, nw, l0, want_loads;
        for (int it = 0; it < 4; it++) begin
            inst = it % 2;
            nw   = 1 + $urandom_range(0, 1);
            tx   = rand_word(inst);
            txw[inst] = tx;
            mosi_q.delete();
            last = '0;
            for (int k = 0; k < nw; k++) begin
                last = rand_word(inst);
                fill_mosi(inst, last);
            end
            want_loads = (f_cpha(inst) == 0) ? nw + 1 : nw;
            l0 = nload[inst];
            drive_frame(inst, nw * f_w(inst), 1'b0, 1'b0);
            n_checks++; if (rxw[inst] !== last) $display("FAIL rnd%0d_rx_word got %h want %h", it, rxw[inst], last); else n_pass++;
            n_checks++; if (nload[inst] - l0 !== want_loads) $display("FAIL rnd%0d_tx_loads got %0d want %0d", it, nload[inst] - l0, want_loads); else n_pass++;
            for (int k = 0; k < nw; k++) begin
                got = recon(inst, k * f_w(inst));
                n_checks++; if (got !== tx) $display("FAIL rnd%0d_cipo%0d got %h want %h", it, k, got, tx); else n_pass++;
            end
            ack_word(inst);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            sck[i]  = f_cpol(i);
            cs[i]   = 1'b1;
            copi[i] = 1'b0;
            ack[i]  = 1'b0;
            txw[i]  = '0;
        end
        test_reset();
        test_busy();
        test_mode0_word();
        test_mode3_word();
        test_back_to_back();
        test_partial();
        test_ack_same_cycle();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
